risc_toy_mem_responder: RTL and testbench

//  Memory-side responder for the RISC_TOY core's instruction and data ports.

---
 rtl/risc_toy_mem_responder.sv | 142 ++++++++++++++
 tb/tb_risc_toy_mem_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/risc_toy_mem_responder.sv
// Memory-side responder for the RISC_TOY core: IMEM fetch port, DMEM load/store port,
// a two-word MMIO window (CYCLE, TOHOST) and a loader port for program/data images.
module risc_toy_mem_responder #(
    parameter int          IAW       = 10,
    parameter int          DAW       = 10,
    parameter logic [29:0] MMIO_BASE = 30'h3FFF_FF00,
    parameter int          LAW       = (IAW > DAW) ? IAW : DAW
) (
    input  logic           CLK,
    input  logic           RSTN,
    input  logic           IREQ,
    input  logic [29:0]    IADDR,
    output logic [31:0]    INSTR,
    input  logic           DREQ,
    input  logic           DRW,
    input  logic [29:0]    DADDR,
    input  logic [31:0]    DWDATA,
    output logic [31:0]    DRDATA,
    input  logic           LD_WE,
    input  logic           LD_SEL,
    input  logic [LAW-1:0] LD_ADDR,
    input  logic [31:0]    LD_DATA,
    output logic           HALT,
    output logic [31:0]    HALT_CODE,
    output logic           ERR
);

    localparam logic [29:0] CYCLE_ADDR  = MMIO_BASE;
    localparam logic [29:0] TOHOST_ADDR = MMIO_BASE + 30'd1;

    logic [31:0] imem [2**IAW];
    logic [31:0] dmem [2**DAW];

    logic [31:0] instr_q, instr_d;
    logic [31:0] drdata_q, drdata_d;
    logic        halt_q, halt_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic        err_q, err_d;
    logic [31:0] cycle_q, cycle_d;

    logic [IAW-1:0] iaddr_idx;
    logic [DAW-1:0] daddr_idx;
    logic [IAW-1:0] ld_iaddr;
    logic [DAW-1:0] ld_daddr;
    logic           ld_imem_we;
    logic           ld_dmem_we;
    logic           ld_i_hit;
    logic           ld_d_hit;
    logic           is_cycle;
    logic           is_tohost;
    logic           is_dmem;
    logic           dmem_st_we;

    assign iaddr_idx  = IADDR[IAW-1:0];
    assign daddr_idx  = DADDR[DAW-1:0];
    assign ld_iaddr   = LD_ADDR[IAW-1:0];
    assign ld_daddr   = LD_ADDR[DAW-1:0];
    assign ld_imem_we = LD_WE && !LD_SEL;
    assign ld_dmem_we = LD_WE && LD_SEL;
    assign ld_i_hit   = ld_imem_we && (ld_iaddr == iaddr_idx);
    assign ld_d_hit   = ld_dmem_we && (ld_daddr == daddr_idx);

    // MMIO words are checked first so the window wins even if it aliases DMEM.
    assign is_cycle  = (DADDR == CYCLE_ADDR);
    assign is_tohost = (DADDR == TOHOST_ADDR);
    assign is_dmem   = (DADDR[29:DAW] == '0);

    always_comb begin
        instr_d     = instr_q;
        drdata_d    = drdata_q;
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        err_d       = err_q;
        cycle_d     = halt_q ? cycle_q : cycle_q + 32'd1;
        dmem_st_we  = 1'b0;

        if (IREQ) begin
            if (IADDR[29:IAW] != '0) begin
                instr_d = '0;
                err_d   = 1'b1;
            end else if (ld_i_hit) begin
                instr_d = LD_DATA;
            end else begin
                instr_d = imem[iaddr_idx];
            end
        end

        if (DREQ) begin
            if (is_cycle) begin
                if (!DRW) drdata_d = cycle_q;
            end else if (is_tohost) begin
                if (DRW) begin
                    if (!halt_q) begin
                        halt_d      = 1'b1;
                        halt_code_d = DWDATA;
                    end
                end else begin
                    drdata_d = halt_code_q;
                end
            end else if (is_dmem) begin
                // A same-word loader write takes the slot; the store is silently dropped.
                if (DRW) dmem_st_we = !ld_d_hit;
                else     drdata_d   = ld_d_hit ? LD_DATA : dmem[daddr_idx];
            end else begin
                err_d = 1'b1;
                if (!DRW) drdata_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            instr_q     <= '0;
            drdata_q    <= '0;
            halt_q      <= 1'b0;
            halt_code_q <= '0;
            err_q       <= 1'b0;
            cycle_q     <= '0;
        end else begin
            instr_q     <= instr_d;
            drdata_q    <= drdata_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            err_q       <= err_d;
            cycle_q     <= cycle_d;
        end
    end

    // Arrays keep their contents across reset so images loaded beforehand survive.
    always_ff @(posedge CLK) begin
        if (ld_imem_we) imem[ld_iaddr] <= LD_DATA;
        if (ld_dmem_we) dmem[ld_daddr] <= LD_DATA;
        if (dmem_st_we) dmem[daddr_idx] <= DWDATA;
    end

    assign INSTR     = instr_q;
    assign DRDATA    = drdata_q;
    assign HALT      = halt_q;
    assign HALT_CODE = halt_code_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_risc_toy_mem_responder.sv
// Directed bench for risc_toy_mem_responder: fetch, load/store, MMIO, loader
// collisions, out-of-range handling and asynchronous reset.
module tb_risc_toy_mem_responder;

    localparam logic [29:0] MMIO_BASE = 30'h3FFF_FF00;
    localparam logic [29:0] CYC_A     = MMIO_BASE;
    localparam logic [29:0] HOST_A    = MMIO_BASE + 30'd1;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        IREQ;
    logic [29:0] IADDR;
    logic [31:0] INSTR;
    logic        DREQ;
    logic        DRW;
    logic [29:0] DADDR;
    logic [31:0] DWDATA;
    logic [31:0] DRDATA;
    logic        LD_WE;
    logic        LD_SEL;
    logic [9:0]  LD_ADDR;
    logic [31:0] LD_DATA;
    logic        HALT;
    logic [31:0] HALT_CODE;
    logic        ERR;

    int tests_run = 0;
    int tests_failed = 0;
    int n_edges = 0;
    bit m_halt = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    logic [31:0] first_v;

    risc_toy_mem_responder #(.IAW(10), .DAW(10), .MMIO_BASE(MMIO_BASE)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .IREQ(IREQ), .IADDR(IADDR), .INSTR(INSTR),
        .DREQ(DREQ), .DRW(DRW), .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(DRDATA),
        .LD_WE(LD_WE), .LD_SEL(LD_SEL), .LD_ADDR(LD_ADDR), .LD_DATA(LD_DATA),
        .HALT(HALT), .HALT_CODE(HALT_CODE), .ERR(ERR)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; the model counter tracks CYCLE (counts while out of reset and not halted).
    task automatic tick();
        @(posedge CLK);
        #1;
        if (RSTN && !m_halt) n_edges++;
    endtask

    task automatic ld(input logic sel, input logic [9:0] addr, input logic [31:0] data);
        LD_WE = 1'b1; LD_SEL = sel; LD_ADDR = addr; LD_DATA = data;
        tick();
        LD_WE = 1'b0;
    endtask

    task automatic dwrite(input logic [29:0] addr, input logic [31:0] data);
        DREQ = 1'b1; DRW = 1'b1; DADDR = addr; DWDATA = data;
        tick();
        DREQ = 1'b0; DRW = 1'b0;
    endtask

    task automatic dread(input logic [29:0] addr);
        DREQ = 1'b1; DRW = 1'b0; DADDR = addr;
        tick();
        DREQ = 1'b0;
    endtask

    initial begin
        RSTN = 1'b0; IREQ = 1'b0; IADDR = '0; DREQ = 1'b0; DRW = 1'b0;
        DADDR = '0; DWDATA = '0; LD_WE = 1'b0; LD_SEL = 1'b0; LD_ADDR = '0; LD_DATA = '0;

        // images loaded while held in reset
        ld(1'b0, 10'd0, 32'd11);
        ld(1'b0, 10'd1, 32'd22);
        ld(1'b0, 10'd2, 32'd33);
        ld(1'b0, 10'd3, 32'd44);

        check("rst_instr", INSTR, 32'd0);
        check("rst_drdata", DRDATA, 32'd0);
        check("rst_halt", {31'd0, HALT}, 32'd0);
        check("rst_code", HALT_CODE, 32'd0);
        check("rst_err", {31'd0, ERR}, 32'd0);

        RSTN = 1'b1;

        // sequential fetch, one cycle latency
        exp_q.push_back(32'd11); exp_q.push_back(32'd22);
        exp_q.push_back(32'd33); exp_q.push_back(32'd44);
        for (int i = 0; i < 4; i++) begin
            IREQ = 1'b1; IADDR = 30'(i);
            tick();
            check($sformatf("fetch_%0d", i), INSTR, exp_q.pop_front());
        end
        IREQ = 1'b0; IADDR = 30'd0;
        tick();
        check("fetch_hold", INSTR, 32'd44);

        // store then load
        dwrite(30'd5, 32'hDEADBEEF);
        check("store_keeps_drdata", DRDATA, 32'd0);
        dread(30'd5);
        check("load_after_store", DRDATA, 32'hDEADBEEF);

        // loader write-first on fetch and load
        IREQ = 1'b1; IADDR = 30'd2;
        ld(1'b0, 10'd2, 32'h99);
        IREQ = 1'b0;
        check("fetch_bypass", INSTR, 32'h99);
        DREQ = 1'b1; DRW = 1'b0; DADDR = 30'd7;
        ld(1'b1, 10'd7, 32'h77);
        DREQ = 1'b0;
        check("load_bypass", DRDATA, 32'h77);

        // loader and store on different words both land
        DREQ = 1'b1; DRW = 1'b1; DADDR = 30'd10; DWDATA = 32'h12;
        ld(1'b1, 10'd8, 32'h88);
        DREQ = 1'b0; DRW = 1'b0;
        dread(30'd8);
        check("diff_word_loader", DRDATA, 32'h88);
        dread(30'd10);
        check("diff_word_store", DRDATA, 32'h12);

        // same word: loader wins, no error
        DREQ = 1'b1; DRW = 1'b1; DADDR = 30'd9; DWDATA = 32'h66;
        ld(1'b1, 10'd9, 32'h55);
        DREQ = 1'b0; DRW = 1'b0;
        dread(30'd9);
        check("collide_loader_wins", DRDATA, 32'h55);
        check("collide_no_err", {31'd0, ERR}, 32'd0);

        // CYCLE: exact value and spacing of 3
        exp_v = 32'(n_edges);
        dread(CYC_A);
        check("cycle_value", DRDATA, exp_v);
        first_v = DRDATA;
        dwrite(CYC_A, 32'h1234);
        tick();
        dread(CYC_A);
        check("cycle_delta3", DRDATA - first_v, 32'd3);
        check("cycle_write_no_err", {31'd0, ERR}, 32'd0);

        // out of range
        dread(30'h0000_0400);
        check("oor_rdata", DRDATA, 32'd0);
        check("oor_err", {31'd0, ERR}, 32'd1);
        dread(30'd5);
        check("inrange_after_err", DRDATA, 32'hDEADBEEF);
        check("err_sticky", {31'd0, ERR}, 32'd1);
        IREQ = 1'b1; IADDR = 30'h0000_0400;
        tick();
        IREQ = 1'b0;
        check("fetch_oor", INSTR, 32'd0);

        // TOHOST: first write wins, CYCLE freezes
        dwrite(HOST_A, 32'h2A);
        m_halt = 1'b1;
        check("halt_set", {31'd0, HALT}, 32'd1);
        check("halt_code", HALT_CODE, 32'h2A);
        dwrite(HOST_A, 32'h7);
        check("halt_code_first_wins", HALT_CODE, 32'h2A);
        dread(HOST_A);
        check("tohost_read", DRDATA, 32'h2A);
        exp_v = 32'(n_edges);
        dread(CYC_A);
        check("cycle_frozen_a", DRDATA, exp_v);
        tick(); tick();
        dread(CYC_A);
        check("cycle_frozen_b", DRDATA, exp_v);

        // asynchronous reset mid-run
        RSTN = 1'b0;
        #1;
        check("arst_instr", INSTR, 32'd0);
        check("arst_drdata", DRDATA, 32'd0);
        check("arst_halt", {31'd0, HALT}, 32'd0);
        check("arst_code", HALT_CODE, 32'd0);
        check("arst_err", {31'd0, ERR}, 32'd0);
        tick();
        RSTN = 1'b1;
        n_edges = 0;
        m_halt = 1'b0;
        dread(30'd9);
        check("dmem_survives_reset", DRDATA, 32'h55);
        exp_v = 32'(n_edges);
        dread(CYC_A);
        check("cycle_after_reset", DRDATA, exp_v);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
